// File: rtl/elbertv2_defs.sv
// Shared definitions for the Elbert V2 UART transmit path: state encoding, byte width, index sizing.
// Latency: none (types and constants only).
// Backpressure: not applicable.
package elbertv2_defs;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        OWN  = 1'b1
    } arb_state_t;

    localparam int UART_BYTE_W = 8;

    // Width of an index selecting one of n requesters; never narrower than one bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_priority_select.sv
// Round-robin picker: first set request scanning upward from ptr, wrapping at N_REQ.
// Latency: purely combinational.
// Backpressure: none; valid is simply the OR of all requests.
module rr_priority_select
    import elbertv2_defs::*;
#(
    parameter int N_REQ = 2,
    parameter int IDX_W = idx_w(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic             valid,
    output logic [IDX_W-1:0] idx
);

    logic [IDX_W-1:0] cand;

    // (base + off) mod N_REQ, with base < N_REQ and off < N_REQ.
    function automatic logic [IDX_W-1:0] wrap_add(input logic [IDX_W-1:0] base, input int off);
        int s;
        s = int'(base) + off;
        if (s >= N_REQ) begin
            s = s - N_REQ;
        end
        return IDX_W'(s);
    endfunction

    // Walk offsets from farthest to nearest so the candidate closest to ptr overwrites the rest.
    always_comb begin
        valid = |req;
        idx   = '0;
        cand  = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            cand = wrap_add(ptr, k);
            if (req[cand]) begin
                idx = cand;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-granular round-robin sharing of one uart_tx buffer; optional idle-owner release via UART_TX_ARB_TIMEOUT_EN.
// Latency: grant one cycle after req in IDLE, first write in that same cycle; at most one write every two cycles.
// Backpressure: buffer_full stalls the owner's write (no ack) indefinitely without losing ownership.
module uart_tx_arbiter
    import elbertv2_defs::*;
#(
    parameter int N_REQ          = 2,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [N_REQ-1:0]             req,
    input  logic [N_REQ-1:0]             last,
    input  logic [UART_BYTE_W*N_REQ-1:0] data,
    output logic [N_REQ-1:0]             ack,
    output logic [N_REQ-1:0]             gnt,
    output logic                         busy,
    output logic                         timeout,
    output logic [UART_BYTE_W-1:0]       data_in,
    output logic                         write_buffer,
    input  logic                         buffer_full
);

    localparam int               IDX_W    = idx_w(N_REQ);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_REQ - 1);

    if (N_REQ < 2 || N_REQ > 8 || TIMEOUT_CYCLES < 2) begin : g_param_check
        $error("uart_tx_arbiter: N_REQ must be 2..8 and TIMEOUT_CYCLES at least 2");
    end

    arb_state_t       state_q, state_d;
    logic [IDX_W-1:0] owner_q, owner_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [IDX_W-1:0] owner_inc;
    logic [IDX_W-1:0] sel_idx;
    logic             sel_vld;
    logic             wr_last_q;
    logic             wr;
    logic             pkt_done;
    logic             force_rel;

    rr_priority_select #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_rr_priority_select (
        .req   (req),
        .ptr   (ptr_q),
        .valid (sel_vld),
        .idx   (sel_idx)
    );

    // Skipping the cycle after each write lets buffer_full reflect that write before the next one.
    assign wr        = (state_q == OWN) & req[owner_q] & ~buffer_full & ~wr_last_q;
    assign pkt_done  = wr & last[owner_q];
    assign owner_inc = (owner_q == LAST_IDX) ? '0 : owner_q + IDX_W'(1);

`ifdef UART_TX_ARB_TIMEOUT_EN
    localparam int CNT_W = idx_w(TIMEOUT_CYCLES);

    logic [CNT_W-1:0] idle_cnt_q;

    // Release fires in the cycle the owner is still silent with the count already at the threshold.
    assign force_rel = (state_q == OWN) & ~req[owner_q] &
                       (idle_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    // Count consecutive owned cycles with the owner silent; stalls on buffer_full do not count.
    always_ff @(posedge clk) begin
        if (reset) begin
            idle_cnt_q <= '0;
        end else if ((state_q != OWN) || req[owner_q] || force_rel) begin
            idle_cnt_q <= '0;
        end else begin
            idle_cnt_q <= idle_cnt_q + CNT_W'(1);
        end
    end
`else
    assign force_rel = 1'b0;
`endif

    // State register: FSM state, owner, round-robin start point and write-spacing flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            owner_q   <= '0;
            ptr_q     <= '0;
            wr_last_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            ptr_q     <= ptr_d;
            wr_last_q <= wr;
        end
    end

    // Next state: arbitrate in IDLE, hold ownership until the last byte or a forced release.
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        case (state_q)
            IDLE: begin
                if (sel_vld) begin
                    state_d = OWN;
                    owner_d = sel_idx;
                end
            end
            OWN: begin
                if (pkt_done || force_rel) begin
                    state_d = IDLE;
                    ptr_d   = owner_inc;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs: grant follows the owner, byte lane and ack only during an actual write.
    always_comb begin
        ack          = '0;
        gnt          = '0;
        data_in      = '0;
        write_buffer = wr;
        busy         = (state_q == OWN);
        timeout      = force_rel;
        if (state_q == OWN) begin
            gnt[owner_q] = 1'b1;
        end
        if (wr) begin
            ack[owner_q] = 1'b1;
            data_in      = data[owner_q*UART_BYTE_W +: UART_BYTE_W];
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter with three requesters and a short release threshold.
// Requesters are byte queues that follow the hold-until-ack rule; a cycle model predicts every output.
// Timeout expectations follow whichever build of UART_TX_ARB_TIMEOUT_EN is compiled.
module tb_uart_tx_arbiter;

    localparam int N      = 3;
    localparam int TO_CYC = 16;

    logic           clk = 1'b0;
    logic           reset;
    logic [N-1:0]   req;
    logic [N-1:0]   last;
    logic [8*N-1:0] data;
    logic [N-1:0]   ack;
    logic [N-1:0]   gnt;
    logic           busy;
    logic           timeout;
    logic [7:0]     data_in;
    logic           write_buffer;
    logic           buffer_full;

    always #5 clk = ~clk;

    uart_tx_arbiter #(
        .N_REQ          (N),
        .TIMEOUT_CYCLES (TO_CYC)
    ) u_dut (
        .clk          (clk),
        .reset        (reset),
        .req          (req),
        .last         (last),
        .data         (data),
        .ack          (ack),
        .gnt          (gnt),
        .busy         (busy),
        .timeout      (timeout),
        .data_in      (data_in),
        .write_buffer (write_buffer),
        .buffer_full  (buffer_full)
    );

    int         n_checks = 0;
    int         n_fail   = 0;
    logic [8:0] txq [N][$];
    bit         committed [N];
    bit         bf_hold;
    int         m_owner;
    int         m_ptr;
    bit         m_prev;
    int         log_cyc [$];
    int         log_lane [$];
    logic [7:0] log_byte [$];

    task automatic clear_log();
        log_cyc.delete();
        log_lane.delete();
        log_byte.delete();
    endtask

    task automatic do_reset();
        reset       = 1'b1;
        req         = '0;
        last        = '0;
        data        = '0;
        buffer_full = 1'b0;
        bf_hold     = 1'b0;
        for (int i = 0; i < N; i++) begin
            txq[i].delete();
            committed[i] = 1'b0;
        end
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        m_owner = -1;
        m_ptr   = 0;
        m_prev  = 1'b0;
    endtask

    // Drive queued traffic for ncyc cycles, predicting outputs from the arbitration rules.
    task automatic run(input int ncyc, input bit rnd_gap, input bit rnd_bf,
                       output int n_diff, output string diff_msg);
        logic [N-1:0] e_gnt, e_ack;
        logic         e_wb, e_busy, w;
        logic [7:0]   e_din;
        int           nxt, lane;
        n_diff   = 0;
        diff_msg = "";
        for (int c = 0; c < ncyc; c++) begin
            @(posedge clk);
            #1;
            for (int i = 0; i < N; i++) begin
                if (txq[i].size() > 0 && (committed[i] || !rnd_gap || $urandom_range(0, 3) != 0)) begin
                    req[i]         = 1'b1;
                    data[8*i +: 8] = txq[i][0][7:0];
                    last[i]        = txq[i][0][8];
                    committed[i]   = 1'b1;
                end else begin
                    req[i]         = 1'b0;
                    data[8*i +: 8] = 8'($urandom);
                    last[i]        = 1'($urandom);
                end
            end
            buffer_full = rnd_bf ? ($urandom_range(0, 3) == 0) : bf_hold;
            @(negedge clk);
            e_gnt = '0; e_ack = '0; e_wb = 1'b0; e_busy = 1'b0; e_din = 8'h00; w = 1'b0; nxt = -1;
            if (m_owner < 0) begin
                for (int k = 0; k < N; k++) begin
                    int j;
                    j = (m_ptr + k) % N;
                    if (nxt < 0 && req[j]) nxt = j;
                end
            end else begin
                e_gnt[m_owner] = 1'b1;
                e_busy         = 1'b1;
                w = req[m_owner] && !buffer_full && !m_prev;
                if (w) begin
                    e_wb           = 1'b1;
                    e_ack[m_owner] = 1'b1;
                    e_din          = data[8*m_owner +: 8];
                end
            end
            if ({gnt, ack, write_buffer, data_in, busy, timeout} !== {e_gnt, e_ack, e_wb, e_din, e_busy, 1'b0}) begin
                if (n_diff == 0)
                    diff_msg = $sformatf("c=%0d got gnt=%b ack=%b wb=%b din=%h busy=%b to=%b, want gnt=%b ack=%b wb=%b din=%h busy=%b to=0",
                                         c, gnt, ack, write_buffer, data_in, busy, timeout, e_gnt, e_ack, e_wb, e_din, e_busy);
                n_diff++;
            end
            if (write_buffer) begin
                lane = -1;
                for (int i = 0; i < N; i++) if (ack[i]) lane = i;
                log_cyc.push_back(c);
                log_lane.push_back(lane);
                log_byte.push_back(data_in);
            end
            for (int i = 0; i < N; i++) begin
                if (ack[i] && txq[i].size() > 0) begin
                    if (txq[i][0][8]) committed[i] = 1'b0;
                    void'(txq[i].pop_front());
                end
            end
            if (m_owner < 0) begin
                m_owner = nxt;
                m_prev  = 1'b0;
            end else begin
                m_prev = w;
                if (w && last[m_owner]) begin
                    m_ptr   = (m_owner + 1) % N;
                    m_owner = -1;
                end
            end
        end
    endtask

    task automatic test_reset();
        reset       = 1'b1;
        req         = 3'b111;
        last        = 3'b111;
        data        = 24'hA1B2C3;
        buffer_full = 1'b0;
        bf_hold     = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if ({ack, gnt, busy, timeout, data_in, write_buffer} !== '0) begin
            $display("FAIL reset_outputs got ack=%b gnt=%b busy=%b to=%b din=%h wb=%b, want all 0",
                     ack, gnt, busy, timeout, data_in, write_buffer);
            n_fail++;
        end
        do_reset();
    endtask

    task automatic test_single_packet();
        int    nd;
        string msg;
        int          exp_c [3] = '{1, 3, 5};
        logic [7:0]  exp_b [3] = '{8'h41, 8'h42, 8'h43};
        do_reset();
        clear_log();
        txq[0].push_back({1'b0, 8'h41});
        txq[0].push_back({1'b0, 8'h42});
        txq[0].push_back({1'b1, 8'h43});
        run(8, 1'b0, 1'b0, nd, msg);
        n_checks++;
        if (nd !== 0) begin
            $display("FAIL single_cycles %0d cycles differ, first: %s", nd, msg);
            n_fail++;
        end
        for (int k = 0; k < 3; k++) begin
            n_checks++;
            if (k >= log_cyc.size() || log_cyc[k] !== exp_c[k] || log_lane[k] !== 0 || log_byte[k] !== exp_b[k]) begin
                $display("FAIL single_write%0d got %0d writes (entry cyc/lane/byte if present: %0d/%0d/%h), want cyc %0d lane 0 byte %h",
                         k, log_cyc.size(), (k < log_cyc.size()) ? log_cyc[k] : -1,
                         (k < log_cyc.size()) ? log_lane[k] : -1, (k < log_cyc.size()) ? log_byte[k] : 8'hxx, exp_c[k], exp_b[k]);
                n_fail++;
            end
        end
    endtask

    task automatic test_contention();
        int    nd;
        string msg;
        int          exp_c [6] = '{1, 3, 5, 7, 1, 3};
        int          exp_l [6] = '{0, 0, 1, 1, 0, 1};
        logic [7:0]  exp_b [6] = '{8'h41, 8'h42, 8'h61, 8'h62, 8'h51, 8'h71};
        do_reset();
        clear_log();
        txq[0].push_back({1'b0, 8'h41});
        txq[0].push_back({1'b1, 8'h42});
        txq[1].push_back({1'b0, 8'h61});
        txq[1].push_back({1'b1, 8'h62});
        run(10, 1'b0, 1'b0, nd, msg);
        txq[0].push_back({1'b1, 8'h51});
        txq[1].push_back({1'b1, 8'h71});
        run(8, 1'b0, 1'b0, nd, msg);
        n_checks++;
        if (nd !== 0) begin
            $display("FAIL contention_cycles %0d cycles differ, first: %s", nd, msg);
            n_fail++;
        end
        n_checks++;
        if (log_cyc.size() !== 6) begin
            $display("FAIL contention_count got %0d writes, want 6", log_cyc.size());
            n_fail++;
        end
        for (int k = 0; k < 6; k++) begin
            n_checks++;
            if (k >= log_cyc.size() || log_cyc[k] !== exp_c[k] || log_lane[k] !== exp_l[k] || log_byte[k] !== exp_b[k]) begin
                $display("FAIL contention_write%0d got cyc/lane/byte %0d/%0d/%h, want %0d/%0d/%h", k,
                         (k < log_cyc.size()) ? log_cyc[k] : -1, (k < log_cyc.size()) ? log_lane[k] : -1,
                         (k < log_cyc.size()) ? log_byte[k] : 8'hxx, exp_c[k], exp_l[k], exp_b[k]);
                n_fail++;
            end
        end
    endtask

    task automatic test_buffer_full();
        int    nd;
        string msg;
        do_reset();
        clear_log();
        txq[0].push_back({1'b1, 8'h55});
        bf_hold = 1'b1;
        run(51, 1'b0, 1'b0, nd, msg);
        n_checks++;
        if (nd !== 0 || log_cyc.size() !== 0) begin
            $display("FAIL bf_stall %0d cycles differ, %0d writes while full (want 0), first: %s", nd, log_cyc.size(), msg);
            n_fail++;
        end
        bf_hold = 1'b0;
        run(3, 1'b0, 1'b0, nd, msg);
        n_checks++;
        if (nd !== 0 || log_cyc.size() !== 1 || log_cyc[0] !== 0 || log_byte[0] !== 8'h55) begin
            $display("FAIL bf_release got %0d writes, first cyc %0d byte %h, want 1 write at cyc 0 byte 55 (%0d diffs %s)",
                     log_cyc.size(), (log_cyc.size() > 0) ? log_cyc[0] : -1, (log_byte.size() > 0) ? log_byte[0] : 8'hxx, nd, msg);
            n_fail++;
        end
    endtask

    task automatic test_timeout();
        logic [N-1:0] e_gnt, e_ack;
        logic         e_wb, e_to;
        logic [7:0]   e_din;
        int           ncyc;
`ifdef UART_TX_ARB_TIMEOUT_EN
        ncyc = 20;
`else
        ncyc = 1002;
`endif
        do_reset();
        @(posedge clk);
        #1;
        req = 3'b011;
        data[7:0] = 8'h11; last[0] = 1'b0;
        data[15:8] = 8'h22; last[1] = 1'b1;
        for (int c = 0; c < ncyc; c++) begin
            @(negedge clk);
            e_gnt = 3'b001; e_ack = '0; e_wb = 1'b0; e_to = 1'b0; e_din = 8'h00;
            if (c == 0) e_gnt = '0;
            else if (c == 1) begin e_wb = 1'b1; e_ack = 3'b001; e_din = 8'h11; end
`ifdef UART_TX_ARB_TIMEOUT_EN
            else if (c == 17) e_to = 1'b1;
            else if (c == 18) e_gnt = '0;
            else if (c == 19) begin e_gnt = 3'b010; e_wb = 1'b1; e_ack = 3'b010; e_din = 8'h22; end
`endif
            n_checks++;
            if ({gnt, ack, write_buffer, data_in, busy, timeout} !== {e_gnt, e_ack, e_wb, e_din, |e_gnt, e_to}) begin
                $display("FAIL timeout_c%0d got gnt=%b ack=%b wb=%b din=%h busy=%b to=%b, want gnt=%b ack=%b wb=%b din=%h busy=%b to=%b",
                         c, gnt, ack, write_buffer, data_in, busy, timeout, e_gnt, e_ack, e_wb, e_din, |e_gnt, e_to);
                n_fail++;
            end
            @(posedge clk);
            #1;
            if (c + 1 == 2) req[0] = 1'b0;
        end
        do_reset();
    endtask

    task automatic test_reset_mid_packet();
        int    nd;
        string msg;
        do_reset();
        txq[0].push_back({1'b1, 8'hA0});
        run(3, 1'b0, 1'b0, nd, msg);
        txq[1].push_back({1'b0, 8'hB0});
        txq[1].push_back({1'b0, 8'hB1});
        txq[1].push_back({1'b1, 8'hB2});
        run(2, 1'b0, 1'b0, nd, msg);
        n_checks++;
        if (nd !== 0 || gnt !== 3'b010) begin
            $display("FAIL midreset_setup got gnt=%b with %0d diffs (%s), want gnt=010", gnt, nd, msg);
            n_fail++;
        end
        @(posedge clk);
        #1;
        reset = 1'b1;
        req = 3'b011;
        data[7:0] = 8'hA5; last[0] = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({ack, gnt, busy, timeout, data_in, write_buffer} !== '0) begin
            $display("FAIL midreset_outputs got ack=%b gnt=%b busy=%b to=%b din=%h wb=%b, want all 0",
                     ack, gnt, busy, timeout, data_in, write_buffer);
            n_fail++;
        end
        @(negedge clk);
        n_checks++;
        if (gnt !== 3'b001 || write_buffer !== 1'b1 || data_in !== 8'hA5) begin
            $display("FAIL midreset_ptr got gnt=%b wb=%b din=%h, want gnt=001 wb=1 din=a5", gnt, write_buffer, data_in);
            n_fail++;
        end
        do_reset();
    endtask

    task automatic test_wrap();
        int    nd;
        string msg;
        int exp_l [4] = '{0, 2, 0, 2};
        do_reset();
        clear_log();
        for (int p = 0; p < 3; p++) begin
            txq[0].push_back({1'b1, 8'(8'h30 + p)});
            txq[2].push_back({1'b1, 8'(8'h50 + p)});
        end
        run(14, 1'b0, 1'b0, nd, msg);
        n_checks++;
        if (nd !== 0) begin
            $display("FAIL wrap_cycles %0d cycles differ, first: %s", nd, msg);
            n_fail++;
        end
        for (int k = 0; k < 4; k++) begin
            n_checks++;
            if (k >= log_lane.size() || log_lane[k] !== exp_l[k] || log_cyc[k] !== 2*k + 1) begin
                $display("FAIL wrap_grant%0d got lane %0d at cyc %0d, want lane %0d at cyc %0d", k,
                         (k < log_lane.size()) ? log_lane[k] : -1, (k < log_cyc.size()) ? log_cyc[k] : -1, exp_l[k], 2*k + 1);
                n_fail++;
            end
        end
    endtask

    task automatic test_random();
        int    nd, left;
        string msg;
        do_reset();
        clear_log();
        for (int i = 0; i < N; i++) begin
            for (int p = 0; p < 3; p++) begin
                int len;
                len = $urandom_range(1, 4);
                for (int b = 0; b < len; b++) begin
                    logic lb;
                    lb = (b == len - 1);
                    txq[i].push_back({lb, 8'($urandom)});
                end
            end
        end
        run(400, 1'b1, 1'b1, nd, msg);
        n_checks++;
        if (nd !== 0) begin
            $display("FAIL random_cycles %0d cycles differ, first: %s", nd, msg);
            n_fail++;
        end
        left = 0;
        for (int i = 0; i < N; i++) left += txq[i].size();
        n_checks++;
        if (left !== 0) begin
            $display("FAIL random_drain got %0d bytes still queued, want 0", left);
            n_fail++;
        end
    endtask

    initial begin
        test_reset();
        test_single_packet();
        test_contention();
        test_buffer_full();
        test_timeout();
        test_reset_mid_packet();
        test_wrap();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
